// File: rtl/noc_pkg.sv
// Shared constants and helpers for the mesh router: port numbering,
// flit field offsets and the XY dimension-ordered route function.
package noc_pkg;

  localparam int NP  = 5;
  localparam int P_L = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_N = 3;
  localparam int P_S = 4;

  typedef logic [NP-1:0] port_vec_t;

  function automatic int dst_x_lsb(input int flit_w, input int x_w);
    return flit_w - x_w;
  endfunction

  function automatic int dst_y_lsb(input int flit_w, input int x_w, input int y_w);
    return flit_w - x_w - y_w;
  endfunction

  // X is resolved completely before Y, which keeps mesh routing deadlock-free.
  function automatic port_vec_t xy_route(input int dst_x, input int dst_y,
                                         input int my_x,  input int my_y);
    port_vec_t dir;
    dir = '0;
    if (dst_x > my_x)      dir[P_E] = 1'b1;
    else if (dst_x < my_x) dir[P_W] = 1'b1;
    else if (dst_y > my_y) dir[P_N] = 1'b1;
    else if (dst_y < my_y) dir[P_S] = 1'b1;
    else                   dir[P_L] = 1'b1;
    return dir;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Input FIFO for one router port: wr_en/full push side with one slot of
// slack, head-of-line read side, and a sticky overflow flag for dropped pushes.
module noc_in_fifo #(
  parameter int FLIT_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_pop,
  output logic [FLIT_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;

  // Full one entry early: the upstream sees in_full a cycle late.
  assign o_full   = (r_count >= (AW+1)'(DEPTH-1));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_wr_en & ~o_full;
  assign w_pop    = i_pop & ~o_empty;
  assign o_head   = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

  // NOTE: storage has no reset; only pointers and count need a defined value,
  // and leaving the array unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_wr_en && o_full) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/noc_mesh_router.sv
// Five-port XY mesh router: per-input FIFOs, dimension-ordered routing on
// FIFO heads, per-output round-robin arbitration and registered outputs.
module noc_mesh_router
  import noc_pkg::*;
#(
  parameter int FLIT_W = 40,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NP-1:0]        in_wr_en,
  input  logic [NP*FLIT_W-1:0] in_data,
  output logic [NP-1:0]        in_full,
  output logic [NP-1:0]        out_wr_en,
  output logic [NP*FLIT_W-1:0] out_data,
  input  logic [NP-1:0]        out_next_full,
  output logic [NP-1:0]        overflow
);

  localparam int X_LSB = dst_x_lsb(FLIT_W, X_W);
  localparam int Y_LSB = dst_y_lsb(FLIT_W, X_W, Y_W);

  logic [FLIT_W-1:0]    w_head  [NP];
  port_vec_t            w_route [NP];
  logic [NP-1:0]        w_empty;
  logic [NP-1:0]        w_pop;
  logic [NP-1:0]        w_grant_vld;
  logic [2:0]           w_winner [NP];
  logic [2:0]           r_rr_ptr [NP];
  logic [NP-1:0]        r_out_wr_en;
  logic [NP*FLIT_W-1:0] r_out_data;

  for (genvar p = 0; p < NP; p++) begin : g_in
    noc_in_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (in_wr_en[p]),
      .i_data     (in_data[p*FLIT_W +: FLIT_W]),
      .i_pop      (w_pop[p]),
      .o_head     (w_head[p]),
      .o_empty    (w_empty[p]),
      .o_full     (in_full[p]),
      .o_overflow (overflow[p])
    );

    assign w_route[p] = w_empty[p] ? '0 :
                        xy_route(int'(w_head[p][X_LSB +: X_W]),
                                 int'(w_head[p][Y_LSB +: Y_W]), MY_X, MY_Y);
  end

  // Each head has a one-hot route, so an input can win at most one output
  // and w_pop never needs to arbitrate between outputs.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum         = '0;
    idx         = '0;
    w_pop       = '0;
    w_grant_vld = '0;
    for (int o = 0; o < NP; o++) begin
      w_winner[o] = '0;
      for (int k = 0; k < NP; k++) begin
        sum = {1'b0, r_rr_ptr[o]} + 4'(k);
        if (sum >= 4'(NP)) sum = sum - 4'(NP);
        idx = sum[2:0];
        if (!w_grant_vld[o] && !out_next_full[o] && w_route[idx][o]) begin
          w_grant_vld[o] = 1'b1;
          w_winner[o]    = idx;
          w_pop[idx]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_wr_en <= '0;
      r_out_data  <= '0;
      for (int o = 0; o < NP; o++) r_rr_ptr[o] <= '0;
    end else begin
      r_out_wr_en <= w_grant_vld;
      for (int o = 0; o < NP; o++) begin
        if (w_grant_vld[o]) begin
          r_out_data[o*FLIT_W +: FLIT_W] <= w_head[w_winner[o]];
          r_rr_ptr[o] <= (w_winner[o] == 3'(NP-1)) ? 3'd0 : w_winner[o] + 3'd1;
        end
      end
    end
  end

  assign out_wr_en = r_out_wr_en;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_noc_mesh_router.sv
// Self-checking bench for noc_mesh_router at MY=(1,1): a queue-based model
// predicts every output each cycle; directed scenarios add literal expectations.
module tb_noc_mesh_router;

  localparam int FW   = 40;
  localparam int N    = 5;
  localparam int DEP  = 4;
  localparam int MYX  = 1;
  localparam int MYY  = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_wr_en;
  logic [N*FW-1:0] in_data;
  logic [N-1:0]    in_full;
  logic [N-1:0]    out_wr_en;
  logic [N*FW-1:0] out_data;
  logic [N-1:0]    out_next_full;
  logic [N-1:0]    overflow;

  noc_mesh_router #(
    .FLIT_W (FW), .X_W (2), .Y_W (2), .MY_X (MYX), .MY_Y (MYY), .DEPTH (DEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_wr_en      (in_wr_en),
    .in_data       (in_data),
    .in_full       (in_full),
    .out_wr_en     (out_wr_en),
    .out_data      (out_data),
    .out_next_full (out_next_full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per input, expected registered outputs.
  logic [FW-1:0] mq [N][$];
  int            rr [N];
  logic [N-1:0]  exp_wr;
  logic [FW-1:0] exp_d [N];
  logic [N-1:0]  exp_ovf;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int x, input int y, input int pl);
    logic [1:0]  fx;
    logic [1:0]  fy;
    logic [35:0] fp;
    fx = 2'(x);
    fy = 2'(y);
    fp = 36'(pl);
    return {fx, fy, fp};
  endfunction

  function automatic int route_of(input logic [FW-1:0] f);
    int dx;
    int dy;
    dx = int'(f[39:38]);
    dy = int'(f[37:36]);
    if (dx > MYX) return 1;
    if (dx < MYX) return 2;
    if (dy > MYY) return 3;
    if (dy < MYY) return 4;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      rr[i]    = 0;
      exp_d[i] = '0;
    end
    exp_wr  = '0;
    exp_ovf = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] pop;
    logic [N-1:0] pre_full;
    bit           done;
    int           i;
    pop    = '0;
    exp_wr = '0;
    for (int o = 0; o < N; o++) begin
      done = 0;
      if (!out_next_full[o]) begin
        for (int k = 0; k < N; k++) begin
          i = (rr[o] + k) % N;
          if (!done && mq[i].size() > 0 && route_of(mq[i][0]) == o) begin
            done     = 1;
            exp_wr[o] = 1'b1;
            exp_d[o]  = mq[i][0];
            pop[i]    = 1'b1;
            rr[o]     = (i + 1) % N;
          end
        end
      end
    end
    for (int j = 0; j < N; j++) pre_full[j] = (mq[j].size() >= DEP - 1);
    for (int j = 0; j < N; j++) if (pop[j]) void'(mq[j].pop_front());
    for (int j = 0; j < N; j++) begin
      if (in_wr_en[j]) begin
        if (pre_full[j]) exp_ovf[j] = 1'b1;
        else             mq[j].push_back(in_data[j*FW +: FW]);
      end
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] exp_full;
    for (int j = 0; j < N; j++) exp_full[j] = (mq[j].size() >= DEP - 1);
    check("out_wr_en", 64'(out_wr_en), 64'(exp_wr));
    check("in_full",   64'(in_full),   64'(exp_full));
    check("overflow",  64'(overflow),  64'(exp_ovf));
    for (int o = 0; o < N; o++)
      check($sformatf("out_data[%0d]", o), 64'(out_data[o*FW +: FW]), 64'(exp_d[o]));
  endtask

  // One clock: inputs are already set; model advances on the edge, DUT sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic push1(input int p, input logic [FW-1:0] f);
    in_wr_en    = '0;
    in_data     = '0;
    in_wr_en[p] = 1'b1;
    in_data[p*FW +: FW] = f;
  endtask

  task automatic idle();
    in_wr_en = '0;
    in_data  = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_out_wr_en", 64'(out_wr_en), 64'd0);
    check("rst_out_data",  64'(out_data == '0), 64'd1);
    check("rst_in_full",   64'(in_full), 64'd0);
    check("rst_overflow",  64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    int per_src [4];
    int tag;

    rst = 1'b1;
    out_next_full = '0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_wr_en", 64'(out_wr_en), 64'd0);
    check("reset_out_data",  64'(out_data == '0), 64'd1);
    check("reset_in_full",   64'(in_full), 64'd0);
    check("reset_overflow",  64'(overflow), 64'd0);
    rst = 1'b0;

    // Local inject to (2,1): East pulse two edges after the push.
    push1(0, mk(2, 1, 'hA5));
    cycle();
    check("lat_e0_wr", 64'(out_wr_en), 64'd0);
    idle();
    cycle();
    check("lat_e1_wr",   64'(out_wr_en), 64'b00010);
    check("lat_e1_data", 64'(out_data[1*FW +: FW]), 64'(mk(2, 1, 'hA5)));
    cycle();
    check("lat_e2_wr", 64'(out_wr_en), 64'd0);

    // From West: (1,0) exits South, then (1,1) exits Local.
    push1(2, mk(1, 0, 'h11));
    cycle();
    push1(2, mk(1, 1, 'h22));
    cycle();
    idle();
    check("west_south_wr",   64'(out_wr_en), 64'b10000);
    check("west_south_data", 64'(out_data[4*FW +: FW]), 64'(mk(1, 0, 'h11)));
    cycle();
    check("west_local_wr",   64'(out_wr_en), 64'b00001);
    check("west_local_data", 64'(out_data[0 +: FW]), 64'(mk(1, 1, 'h22)));
    repeat (2) cycle();

    // L, E, W, N all target Local: grants rotate L, E, W, N.
    apply_reset();
    grants = 0;
    for (int s = 0; s < 4; s++) per_src[s] = 0;
    for (int c = 0; c < 60 && grants < 20; c++) begin
      idle();
      for (int s = 0; s < 4; s++) begin
        if (mq[s].size() < DEP - 1) begin
          in_wr_en[s] = 1'b1;
          in_data[s*FW +: FW] = mk(1, 1, c * 16 + s);
        end
      end
      cycle();
      if (out_wr_en[0]) begin
        tag = int'(out_data[3:0]);
        check("rr_order", 64'(tag), 64'(grants % 4));
        if (tag < 4) per_src[tag]++;
        grants++;
      end
    end
    check("rr_total", 64'(grants), 64'd20);
    for (int s = 0; s < 4; s++) check($sformatf("rr_share[%0d]", s), 64'(per_src[s]), 64'd5);
    idle();
    repeat (8) cycle();

    // East blocked downstream: three flits fill Local to in_full, then drain back to back.
    apply_reset();
    out_next_full = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      push1(0, mk(3, 2, 'h300 + k));
      cycle();
    end
    idle();
    check("stall_in_full", 64'(in_full[0]), 64'd1);
    repeat (2) begin
      cycle();
      check("stall_no_out", 64'(out_wr_en), 64'd0);
    end
    out_next_full = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("drain_pulse", 64'(out_wr_en), 64'b00010);
      check("drain_data",  64'(out_data[1*FW +: FW]), 64'(mk(3, 2, 'h300 + k)));
    end
    cycle();
    check("drain_done", 64'(out_wr_en), 64'd0);
    check("drain_ovf",  64'(overflow), 64'd0);

    // Five pushes into a stalled input: pushes beyond in_full are dropped and stick.
    apply_reset();
    out_next_full = '1;
    for (int k = 0; k < 5; k++) begin
      push1(2, mk(1, 0, 'h500 + k));
      cycle();
    end
    idle();
    check("ovf_set", 64'(overflow), 64'b00100);
    out_next_full = '0;
    repeat (6) cycle();
    check("ovf_sticky", 64'(overflow), 64'b00100);

    // Reset with flits queued: everything clears, nothing emerges afterwards.
    apply_reset();
    push1(0, mk(2, 1, 'h6A));
    cycle();
    idle();
    repeat (2) cycle();
    out_next_full = '1;
    push1(0, mk(2, 1, 'h6B));
    cycle();
    push1(0, mk(1, 2, 'h6C));
    cycle();
    idle();
    check("pre_rst_data", 64'(out_data[1*FW +: FW]), 64'(mk(2, 1, 'h6A)));
    apply_reset();
    out_next_full = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_rst_quiet", 64'(out_wr_en), 64'd0);
    end

    // Randomised traffic with random downstream backpressure.
    for (int c = 0; c < 600; c++) begin
      idle();
      for (int p = 0; p < N; p++) begin
        in_wr_en[p] = ($urandom_range(0, 1) == 1);
        in_data[p*FW +: FW] = mk($urandom_range(0, 3), $urandom_range(0, 3), int'($urandom));
        out_next_full[p] = ($urandom_range(0, 3) == 0);
      end
      cycle();
    end
    idle();
    out_next_full = '0;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
